// File: rtl/store_pkg.sv
// Shared types for the narrowing store path.
// Size encodings, FSM states and the data word width.
package store_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_e;

  // Forces the low address bits onto the natural boundary of the size.
  function automatic logic [1:0] align_lo(
    input size_e     size,
    input logic [1:0] lo
  );
    logic [1:0] r;
    r = lo;
    if (size == SZ_HALF) r[0] = 1'b0;
    if (size == SZ_WORD) r = 2'b00;
    return r;
  endfunction

  function automatic logic is_misaligned(
    input size_e     size,
    input logic [1:0] lo
  );
    return ((size == SZ_HALF) && lo[0]) ||
           ((size == SZ_WORD) && (lo != 2'b00));
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian lane merge of store data into a read-back word.
// Word and reserved sizes pass the store data straight through.
module byte_lane_merge
  import store_pkg::*;
(
  input  logic [WORD_W-1:0] old_word,
  input  logic [WORD_W-1:0] data,
  input  size_e             size,
  input  logic [1:0]        lane,
  output logic [WORD_W-1:0] merged
);

  // Overlay the selected lanes, keep the rest.
  always_comb begin
    merged = old_word;
    unique case (1'b1)
      size == SZ_BYTE:
        merged[{lane, 3'b000} +: 8] = data[7:0];
      size == SZ_HALF:
        merged[{lane[1], 4'b0000} +: 16] = data[15:0];
      default:
        merged = data;
    endcase
  end

endmodule

// File: rtl/store_rmw_narrow.sv
// Narrowing store unit: sub-word stores read-modify-write a word memory.
// Build option: STORE_MISALIGN_TRAP_EN rejects misaligned half/word stores.
module store_rmw_narrow
  import store_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_data,
  input  logic [1:0]        req_size,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [31:0]       mem_rd_data,
  output logic              mem_wr_en,
  output logic [31:0]       mem_wr_data
);

  localparam logic [1:0] CNT_INIT = 2'(RD_LAT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          lo_q;
  logic [WORD_W-1:0]   data_q;
  size_e               size_q;
  logic [WORD_W-1:0]   rdata_q;
  logic [1:0]          cnt_q;
  size_e               size_in;
  logic                reject;
  logic                unused_hi;

  assign size_in   = size_e'(req_size);
  assign unused_hi = ^req_addr[31:ADDR_W+2];

`ifdef STORE_MISALIGN_TRAP_EN
  assign reject = (size_in == SZ_RSVD) ||
                  is_misaligned(size_in, req_addr[1:0]);
`else
  assign reject = (size_in == SZ_RSVD);
`endif

  // State register; reset aborts any sequence in flight.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state and strobes.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (reject)                 state_d = DONE;
          else if (size_in == SZ_WORD) state_d = WRITE;
          else                        state_d = READ;
        end
      end
      READ: begin
        mem_rd_en = 1'b1;
        state_d   = WAIT;
      end
      // Covers the memory pipeline; data is captured on the last cycle.
      WAIT: begin
        if (cnt_q == 2'd0) state_d = WRITE;
      end
      WRITE: begin
        mem_wr_en = 1'b1;
        done      = 1'b1;
        state_d   = IDLE;
      end
      DONE: begin
        done    = 1'b1;
        err     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request latch, latency counter and read-back capture.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      addr_q  <= '0;
      lo_q    <= '0;
      data_q  <= '0;
      size_q  <= SZ_BYTE;
      rdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      if (state_q == IDLE && req_valid) begin
        addr_q <= req_addr[ADDR_W+1:2];
        lo_q   <= align_lo(size_in, req_addr[1:0]);
        data_q <= req_data;
        size_q <= size_in;
      end
      if (state_q == READ)
        cnt_q <= CNT_INIT;
      else if (state_q == WAIT && cnt_q != 2'd0)
        cnt_q <= cnt_q - 2'd1;
      if (state_q == WAIT && cnt_q == 2'd0)
        rdata_q <= mem_rd_data;
    end
  end

  assign mem_addr = addr_q;

  byte_lane_merge u_merge (
    .old_word (rdata_q),
    .data     (data_q),
    .size     (size_q),
    .lane     (lo_q),
    .merged   (mem_wr_data)
  );

endmodule

// File: tb/tb_store_rmw_narrow.sv
// Bench for store_rmw_narrow with RD_LAT=1 and RD_LAT=3 instances.
// Expected writes come from a byte-enable model over bench memories.
module tb_store_rmw_narrow;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        v1, v3;
  logic [31:0] a, d;
  logic [1:0]  sz;

  logic        rdy1, dn1, er1, re1, we1;
  logic [9:0]  ma1;
  logic [31:0] rd1, wd1;
  logic        rdy3, dn3, er3, re3, we3;
  logic [9:0]  ma3;
  logic [31:0] rd3, wd3;

  logic [31:0] mem1 [1024];
  logic [31:0] mem3 [1024];
  logic [31:0] p3 [3];
  logic [2:0]  pv = 3'b000;
  logic        pl_en = 1'b0;
  int          pl_w;
  logic [9:0]  pl_a;
  logic [31:0] pl_d;

  int checks = 0;
  int failures = 0;
  int rdc1 = 0, wrc1 = 0, rdc3 = 0, wrc3 = 0;

  typedef struct {
    bit          err;
    logic [9:0]  wa;
    logic [31:0] wd;
    int          lat;
  } exp_t;
  exp_t sb[$];

  store_rmw_narrow #(.ADDR_W(10), .RD_LAT(1)) dut1 (
    .Clk(clk), .Rst_n(rst_n),
    .req_valid(v1), .req_ready(rdy1),
    .req_addr(a), .req_data(d), .req_size(sz),
    .done(dn1), .err(er1),
    .mem_addr(ma1), .mem_rd_en(re1), .mem_rd_data(rd1),
    .mem_wr_en(we1), .mem_wr_data(wd1)
  );

  store_rmw_narrow #(.ADDR_W(10), .RD_LAT(3)) dut3 (
    .Clk(clk), .Rst_n(rst_n),
    .req_valid(v3), .req_ready(rdy3),
    .req_addr(a), .req_data(d), .req_size(sz),
    .done(dn3), .err(er3),
    .mem_addr(ma3), .mem_rd_en(re3), .mem_rd_data(rd3),
    .mem_wr_en(we3), .mem_wr_data(wd3)
  );

  // Memory models: latency 1 and latency 3, garbage when not valid.
  always @(posedge clk) begin
    rd1 <= re1 ? mem1[ma1] : 32'hBAD0_BAD1;
    if (we1) mem1[ma1] <= wd1;
    if (pl_en && pl_w == 1) mem1[pl_a] <= pl_d;
    if (re1) rdc1++;
    if (we1) wrc1++;
    pv    <= {pv[1:0], re3};
    p3[0] <= mem3[ma3];
    p3[1] <= p3[0];
    p3[2] <= p3[1];
    if (we3) mem3[ma3] <= wd3;
    if (pl_en && pl_w == 3) mem3[pl_a] <= pl_d;
    if (re3) rdc3++;
    if (we3) wrc3++;
  end
  assign rd3 = pv[2] ? p3[2] : 32'hBAD0_BAD3;

  function automatic logic [31:0] model(
    input logic [31:0] old, input logic [31:0] data,
    input logic [1:0] size, input logic [1:0] lo
  );
    logic [3:0]  be;
    logic [31:0] src, r;
    case (size)
      2'b00: begin be = 4'b0001 << lo; src = {4{data[7:0]}}; end
      2'b01: begin
        be  = lo[1] ? 4'b1100 : 4'b0011;
        src = {2{data[15:0]}};
      end
      default: begin be = 4'hF; src = data; end
    endcase
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? src[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  task automatic preload(input int w, input logic [9:0] wa,
                         input logic [31:0] val);
    @(negedge clk);
    pl_w = w; pl_a = wa; pl_d = val; pl_en = 1'b1;
    @(posedge clk); #1;
    pl_en = 1'b0;
  endtask

  task automatic store(input int w, input logic [31:0] addr,
                       input logic [31:0] data, input logic [1:0] size,
                       input bit noise);
    exp_t        e;
    logic [31:0] old;
    logic [1:0]  lo;
    bit          mis, got;
    int          n, rd0, wr0, drd, dwr;
    logic        rdy, dn, er, we;
    logic [9:0]  ma;
    logic [31:0] wd;
    e.wa = addr[11:2];
    lo   = addr[1:0];
    if (size == 2'b01) lo[0] = 1'b0;
    if (size == 2'b10) lo = 2'b00;
    mis   = (size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00);
    e.err = (size == 2'b11);
`ifdef STORE_MISALIGN_TRAP_EN
    if (mis) e.err = 1'b1;
`else
    if (mis) e.err = e.err;
`endif
    old   = (w == 3) ? mem3[e.wa] : mem1[e.wa];
    e.wd  = model(old, data, size, lo);
    e.lat = (e.err || size == 2'b10) ? 1 : 2 + ((w == 3) ? 3 : 1);
    sb.push_back(e);
    rd0 = (w == 3) ? rdc3 : rdc1;
    wr0 = (w == 3) ? wrc3 : wrc1;
    @(negedge clk);
    a = addr; d = data; sz = size;
    if (w == 3) v3 = 1'b1; else v1 = 1'b1;
    @(posedge clk); #1;
    rdy = (w == 3) ? rdy3 : rdy1;
    checks++;
    if (rdy !== 1'b0) begin
      failures++;
      $display("FAIL ready_busy w=%0d got=%b want=0", w, rdy);
    end
    if (noise) begin
      a = ~addr; d = ~data; sz = 2'b11;
    end else begin
      v1 = 1'b0; v3 = 1'b0;
    end
    got = 1'b0;
    n   = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      dn = (w == 3) ? dn3 : dn1;
      if (dn === 1'b1) begin
        got = 1'b1;
        n   = i;
        break;
      end
    end
    v1 = 1'b0; v3 = 1'b0;
    a = addr; d = data; sz = size;
    e = sb.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL done_timeout w=%0d addr=%h got=none want=%0d",
               w, addr, e.lat);
    end else begin
      er = (w == 3) ? er3 : er1;
      we = (w == 3) ? we3 : we1;
      ma = (w == 3) ? ma3 : ma1;
      wd = (w == 3) ? wd3 : wd1;
      if (n != e.lat) begin
        failures++;
        $display("FAIL latency w=%0d addr=%h got=%0d want=%0d",
                 w, addr, n, e.lat);
      end
      checks++;
      if (er !== e.err) begin
        failures++;
        $display("FAIL err w=%0d addr=%h got=%b want=%b",
                 w, addr, er, e.err);
      end
      checks++;
      if (we !== !e.err) begin
        failures++;
        $display("FAIL wr_en w=%0d addr=%h got=%b want=%b",
                 w, addr, we, !e.err);
      end
      if (!e.err) begin
        checks++;
        if (ma !== e.wa || wd !== e.wd) begin
          failures++;
          $display("FAIL write w=%0d addr=%h got=%h:%h want=%h:%h",
                   w, addr, ma, wd, e.wa, e.wd);
        end
      end
    end
    @(posedge clk); #1;
    drd = ((w == 3) ? rdc3 : rdc1) - rd0;
    dwr = ((w == 3) ? wrc3 : wrc1) - wr0;
    checks++;
    if (drd != ((!e.err && size != 2'b10) ? 1 : 0) ||
        dwr != (e.err ? 0 : 1)) begin
      failures++;
      $display("FAIL strobes w=%0d addr=%h got=rd%0d/wr%0d want_err=%b",
               w, addr, drd, dwr, e.err);
    end
    rdy = (w == 3) ? rdy3 : rdy1;
    checks++;
    if (rdy !== 1'b1) begin
      failures++;
      $display("FAIL ready_idle w=%0d got=%b want=1", w, rdy);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rdy1, dn1, er1, re1, we1} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctl got=%b want=10000",
               {rdy1, dn1, er1, re1, we1});
    end
    checks++;
    if (ma1 !== 10'd0 || wd1 !== 32'd0) begin
      failures++;
      $display("FAIL reset_bus got=%h:%h want=0:0", ma1, wd1);
    end
    checks++;
    if ({rdy3, dn3, er3, re3, we3} !== 5'b10000) begin
      failures++;
      $display("FAIL reset_ctl3 got=%b want=10000",
               {rdy3, dn3, er3, re3, we3});
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      preload(1, 10'(i), 32'h1000_0000 + 32'(i));
      preload(3, 10'(i), 32'h3000_0000 + 32'(i));
    end
  endtask

  task automatic test_word();
    store(1, 32'h0000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0);
  endtask

  task automatic test_byte();
    preload(1, 10'd4, 32'h1122_3344);
    store(1, 32'h0000_0013, 32'h1234_56AB, 2'b00, 1'b0);
    checks++;
    if (mem1[4] !== 32'hAB22_3344) begin
      failures++;
      $display("FAIL byte_mem got=%h want=AB223344", mem1[4]);
    end
  endtask

  task automatic test_half();
    preload(1, 10'd4, 32'h1122_3344);
    store(1, 32'h0000_0012, 32'h5555_CAFE, 2'b01, 1'b0);
    checks++;
    if (mem1[4] !== 32'hCAFE_3344) begin
      failures++;
      $display("FAIL half_mem got=%h want=CAFE3344", mem1[4]);
    end
    preload(3, 10'd4, 32'h1122_3344);
    store(3, 32'h0000_0012, 32'h5555_CAFE, 2'b01, 1'b0);
    checks++;
    if (mem3[4] !== 32'hCAFE_3344) begin
      failures++;
      $display("FAIL half_mem3 got=%h want=CAFE3344", mem3[4]);
    end
    store(3, 32'h0000_0011, 32'h0000_0077, 2'b00, 1'b0);
  endtask

  task automatic test_misalign();
    preload(1, 10'd4, 32'h1122_3344);
    store(1, 32'h0000_0011, 32'h0000_BEEF, 2'b01, 1'b0);
    store(1, 32'h0000_0016, 32'h0BAD_F00D, 2'b10, 1'b0);
    store(3, 32'h0000_0023, 32'h0000_1234, 2'b01, 1'b0);
  endtask

  task automatic test_reserved();
    store(1, 32'h0000_0014, 32'hFFFF_FFFF, 2'b11, 1'b0);
    store(3, 32'h0000_0018, 32'hFFFF_FFFF, 2'b11, 1'b0);
  endtask

  task automatic test_back_to_back();
    store(1, 32'h0000_0020, 32'h0000_00C1, 2'b00, 1'b1);
    store(1, 32'h0000_0021, 32'h0000_00C2, 2'b00, 1'b0);
    store(1, 32'h0000_0022, 32'h0000_C3C4, 2'b01, 1'b1);
    store(3, 32'h0000_0024, 32'hA5A5_5A5A, 2'b10, 1'b1);
    store(3, 32'h0000_0027, 32'h0000_00D7, 2'b00, 1'b1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      store((i % 2 == 0) ? 1 : 3, 32'($urandom_range(0, 63)),
            $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_wait();
    int          wr0;
    logic [31:0] keep;
    preload(3, 10'd8, 32'h5566_7788);
    keep = mem3[8];
    wr0  = wrc3;
    @(negedge clk);
    a = 32'h0000_0020; d = 32'h0000_9999; sz = 2'b01; v3 = 1'b1;
    @(posedge clk); #1;
    v3 = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rdy3 !== 1'b1 || we3 !== 1'b0 || re3 !== 1'b0) begin
      failures++;
      $display("FAIL rst_wait_ctl got=%b%b%b want=100", rdy3, we3, re3);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (wrc3 != wr0 || mem3[8] !== keep || rdy3 !== 1'b1) begin
      failures++;
      $display("FAIL rst_wait_write got=%0d:%h want=%0d:%h",
               wrc3 - wr0, mem3[8], 0, keep);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    v1 = 1'b0; v3 = 1'b0;
    a = '0; d = '0; sz = '0;
    pl_w = 0; pl_a = '0; pl_d = '0;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_misalign();
    test_reserved();
    test_back_to_back();
    test_random();
    test_reset_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
